// File: rtl/Modules_pkg.sv
// Shared FP functional-unit types and constants used by the FP multiply and divide units.
package Modules_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  // Unpacked-exponent form with explicit hidden bit, used between FU stages.
  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exponent;
    logic [23:0]        mantissa;
  } effective_float_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  localparam int     BIAS       = 127;
  localparam int     DIV_Q_BITS = 26;
  localparam float_t P_INFTY    = 32'h7F80_0000;
  localparam float_t N_INFTY    = 32'hFF80_0000;
  localparam float_t Q_NAN      = 32'h7FC0_0000;
  localparam float_t ZERO       = 32'h0000_0000;

endpackage

// File: rtl/fp_mantissa_divider.sv
// Radix-2 restoring divider for 24-bit significands, one quotient bit per enabled step.
module fp_mantissa_divider
  import Modules_pkg::*;
#(
  parameter int Q_BITS = DIV_Q_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [23:0]       dividend_i,
  input  logic [23:0]       divisor_i,
  output logic [Q_BITS-1:0] quotient_o,
  output logic              remainder_nz_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(Q_BITS);

  logic        [25:0]      rem_q;
  logic        [23:0]      div_q;
  logic        [CNT_W-1:0] cnt_q;
  logic signed [25:0]      diff;
  logic                    fits;

  // Compare-then-shift keeps rem < 2*div, so the first bit is the integer bit of A/B.
  assign diff = $signed(rem_q) - $signed({2'b00, div_q});
  assign fits = ~diff[25];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      quotient_o <= '0;
    end else if (start_i) begin
      rem_q      <= {2'b00, dividend_i};
      div_q      <= divisor_i;
      cnt_q      <= CNT_W'(Q_BITS - 1);
      quotient_o <= '0;
    end else if (en_i) begin
      rem_q      <= fits ? {diff[24:0], 1'b0} : {rem_q[24:0], 1'b0};
      quotient_o <= {quotient_o[Q_BITS-2:0], fits};
      cnt_q      <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o         = (cnt_q == '0);
  assign remainder_nz_o = |rem_q;

endmodule

// File: rtl/fp_div_unit.sv
// Single-precision FP divider: special-case decode, exponent, normalisation and RNE rounding
// around a sequential restoring mantissa divider.
module fp_div_unit
  import Modules_pkg::*;
#(
  parameter int Q_BITS = DIV_Q_BITS,
  parameter int EXP_W  = 10
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clk_en_i,
  input  logic      valid_i,
  input  float_t    dividend_i,
  input  float_t    divisor_i,
  output float_t    to_round_unit_o,
  output logic      valid_o,
  output fu_state_e fu_state_o,
  output logic      overflow_o,
  output logic      underflow_o,
  output logic      invalid_op_o,
  output logic      div_by_zero_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREPARE,
    S_DIVIDE,
    S_NORMALIZE,
    S_VALID
  } state_e;

  localparam logic signed [EXP_W-1:0] BIAS_E  = EXP_W'(BIAS);
  localparam logic signed [EXP_W-1:0] ONE_E   = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] ZERO_E  = '0;
  localparam logic signed [EXP_W-1:0] EMAX_E  = EXP_W'(255);

  function automatic logic [23:0] round_rne(input logic [22:0] mant, input logic guard,
                                            input logic sticky);
    logic inc;
    inc = guard & (sticky | mant[0]);
    return {1'b0, mant} + {23'b0, inc};
  endfunction

  state_e                    state_q;
  float_t                    op_a_q, op_b_q;
  logic                      sign_q;
  logic signed [EXP_W-1:0]   exp_q;

  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;
  logic   special;
  float_t spec_res;
  logic   spec_inv, spec_dbz;
  logic   res_sign;

  logic signed [EXP_W-1:0] exp_a, exp_b, exp_calc;

  logic              div_start, div_en, div_done, rem_nz;
  logic [Q_BITS-1:0] quotient;

  logic [Q_BITS-2:0]       q_norm;
  logic signed [EXP_W-1:0] exp_norm, exp_rnd;
  logic [23:0]             mant_rnd;
  logic                    sticky;
  logic                    ovf, unf;
  float_t                  norm_res;

  assign a_zero = (op_a_q.exponent == 8'h00);
  assign a_inf  = (op_a_q.exponent == 8'hFF) && (op_a_q.mantissa == '0);
  assign a_nan  = (op_a_q.exponent == 8'hFF) && (op_a_q.mantissa != '0);
  assign a_snan = a_nan && !op_a_q.mantissa[22];
  assign b_zero = (op_b_q.exponent == 8'h00);
  assign b_inf  = (op_b_q.exponent == 8'hFF) && (op_b_q.mantissa == '0);
  assign b_nan  = (op_b_q.exponent == 8'hFF) && (op_b_q.mantissa != '0);
  assign b_snan = b_nan && !op_b_q.mantissa[22];

  assign res_sign = op_a_q.sign ^ op_b_q.sign;

  always_comb begin
    special  = 1'b1;
    spec_res = ZERO;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = Q_NAN;
      spec_inv = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = Q_NAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = res_sign ? N_INFTY : P_INFTY;
    end else if (b_zero) begin
      spec_res = res_sign ? N_INFTY : P_INFTY;
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {res_sign, 31'b0};
    end else begin
      special = 1'b0;
    end
  end

  assign exp_a    = $signed({{(EXP_W-8){1'b0}}, op_a_q.exponent});
  assign exp_b    = $signed({{(EXP_W-8){1'b0}}, op_b_q.exponent});
  assign exp_calc = exp_a - exp_b + BIAS_E;

  assign div_start = clk_en_i && (state_q == S_PREPARE) && !special;
  assign div_en    = clk_en_i && (state_q == S_DIVIDE);

  fp_mantissa_divider #(
    .Q_BITS(Q_BITS)
  ) u_mant_div (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (div_start),
    .en_i           (div_en),
    .dividend_i     ({|op_a_q.exponent, op_a_q.mantissa}),
    .divisor_i      ({|op_b_q.exponent, op_b_q.mantissa}),
    .quotient_o     (quotient),
    .remainder_nz_o (rem_nz),
    .done_o         (div_done)
  );

  // Quotient lies in (0.5, 2): a clear top bit means one left shift and exponent decrement.
  assign q_norm   = quotient[Q_BITS-1] ? quotient[Q_BITS-2:0] : {quotient[Q_BITS-3:0], 1'b0};
  assign exp_norm = quotient[Q_BITS-1] ? exp_q : exp_q - ONE_E;
  assign sticky   = (|q_norm[Q_BITS-26:0]) | rem_nz;
  assign mant_rnd = round_rne(q_norm[Q_BITS-2 -: 23], q_norm[Q_BITS-25], sticky);
  assign exp_rnd  = mant_rnd[23] ? exp_norm + ONE_E : exp_norm;
  assign ovf      = (exp_rnd >= EMAX_E);
  assign unf      = (exp_rnd <= ZERO_E);

  always_comb begin
    norm_res = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
    if (ovf) begin
      norm_res = {sign_q, 8'hFF, 23'b0};
    end else if (unf) begin
      norm_res = {sign_q, 31'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      op_a_q          <= ZERO;
      op_b_q          <= ZERO;
      sign_q          <= 1'b0;
      exp_q           <= '0;
      to_round_unit_o <= ZERO;
      valid_o         <= 1'b0;
      fu_state_o      <= FREE;
      overflow_o      <= 1'b0;
      underflow_o     <= 1'b0;
      invalid_op_o    <= 1'b0;
      div_by_zero_o   <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_a_q        <= dividend_i;
            op_b_q        <= divisor_i;
            fu_state_o    <= BUSY;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
            invalid_op_o  <= 1'b0;
            div_by_zero_o <= 1'b0;
            state_q       <= S_PREPARE;
          end
        end
        S_PREPARE: begin
          sign_q <= res_sign;
          exp_q  <= exp_calc;
          if (special) begin
            to_round_unit_o <= spec_res;
            invalid_op_o    <= spec_inv;
            div_by_zero_o   <= spec_dbz;
            valid_o         <= 1'b1;
            state_q         <= S_VALID;
          end else begin
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          if (div_done) state_q <= S_NORMALIZE;
        end
        S_NORMALIZE: begin
          to_round_unit_o <= norm_res;
          overflow_o      <= ovf;
          underflow_o     <= unf & ~ovf;
          valid_o         <= 1'b1;
          state_q         <= S_VALID;
        end
        S_VALID: begin
          valid_o    <= 1'b0;
          fu_state_o <= FREE;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_unit.sv
// Directed bench for fp_div_unit with a queue-based scoreboard of expected results.
module tb_fp_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        valid_i;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic        valid_o;
  logic        fu_state;
  logic        ovf, unf, inv, dbz;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fp_div_unit dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clk_en_i        (clk_en),
    .valid_i         (valid_i),
    .dividend_i      (dividend),
    .divisor_i       (divisor),
    .to_round_unit_o (result),
    .valid_o         (valid_o),
    .fu_state_o      (fu_state),
    .overflow_o      (ovf),
    .underflow_o     (unf),
    .invalid_op_o    (inv),
    .div_by_zero_o   (dbz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Flags are compared as {overflow, underflow, invalid_op, div_by_zero}.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] fl, input int lat,
                        input int stall_at, input int stall_len, input int junk_at);
    exp_t e;
    int   n;
    bit   seen;
    e = '{res: res, flags: fl, lat: lat};
    sb.push_back(e);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    valid_i  = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      valid_i = (junk_at != 0) && (n == junk_at);
      if (valid_i) begin
        dividend = 32'h40C0_0000;
        divisor  = 32'h4000_0000;
      end
      if (stall_at != 0 && n == stall_at) clk_en = 1'b0;
      if (stall_at != 0 && n == stall_at + stall_len) clk_en = 1'b1;
      if (n == 1) check({tag, "_busy_c1"}, 32'(fu_state), 32'd1);
      if (valid_o) begin
        seen = 1'b1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, "_latency"}, 32'(n), 32'(e.lat));
          check({tag, "_result"}, result, e.res);
          check({tag, "_flags"}, {28'b0, ovf, unf, inv, dbz}, {28'b0, e.flags});
          check({tag, "_busy_valid"}, 32'(fu_state), 32'd1);
        end
      end
    end
    valid_i = 1'b0;
    clk_en  = 1'b1;
    if (!seen) check({tag, "_valid_timeout"}, 32'(valid_o), 32'd1);
    @(negedge clk);
    check({tag, "_valid_pulse_end"}, 32'(valid_o), 32'd0);
    check({tag, "_free_after"}, 32'(fu_state), 32'd0);
    check({tag, "_result_hold"}, result, res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst      = 1'b1;
    clk_en   = 1'b1;
    valid_i  = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_state", 32'(fu_state), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {28'b0, ovf, unf, inv, dbz}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("div_6_2",     32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 29, 0, 0, 0);
    run_op("div_1_3",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 29, 0, 0, 5);
    run_op("div_1_0",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001, 2,  0, 0, 0);
    run_op("div_0_0",     32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0010, 2,  0, 0, 0);
    run_op("snan",        32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0010, 2,  0, 0, 0);
    run_op("inf_neg2",    32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, 2,  0, 0, 0);
    run_op("overflow",    32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b1000, 29, 0, 0, 0);
    run_op("underflow",   32'h0080_0000, 32'h4B00_0000, 32'h0000_0000, 4'b0100, 29, 0, 0, 0);
    run_op("neg_stall",   32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 4'b0000, 34, 10, 5, 0);

    // Abort an operation with reset while dividing; no result may ever appear.
    @(negedge clk);
    dividend = 32'h40C0_0000;
    divisor  = 32'h4000_0000;
    valid_i  = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_free", 32'(fu_state), 32'd0);
    check("abort_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);

    run_op("div_6_2_again", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 29, 0, 0, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
